// File: rtl/flag_hazard_scheduler.sv
// flag_hazard_scheduler
//   Owns the NZCV status register and holds decode while a conditional
//   instruction would read flags that an older, still in-flight S=1
//   instruction has not yet written from EXE.
//
// Ports
//   clk, rst_n      rising-edge clock, async active-low reset
//   id_valid        decode holds a valid instruction
//   id_cond         decode condition field (0xE/0xF never read flags)
//   id_s            decode instruction sets flags
//   flush           squash everything younger than EXE (one cycle)
//   exe_s_wr        EXE writes flags this cycle
//   exe_flags       new flags {N,Z,C,V}
//   sr              architectural status register {N,Z,C,V}
//   chk_sr          flags forwarded to the condition checker
//   chk_cond        id_cond pass-through
//   id_stall        hold decode this cycle
//   pend_cnt        in-flight flag-writer count
//   underflow_err   sticky: EXE wrote flags with nothing in flight
module flag_hazard_scheduler #(
  parameter int MAX_PEND = 2,
  parameter int CNT_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_cond,
  input  logic             id_s,
  input  logic             flush,
  input  logic             exe_s_wr,
  input  logic [3:0]       exe_flags,
  output logic [3:0]       sr,
  output logic [3:0]       chk_sr,
  output logic [3:0]       chk_cond,
  output logic             id_stall,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             underflow_err
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PEND);

  logic             retire;
  logic [CNT_W-1:0] eff;
  logic             uncond;
  logic             hazard;
  logic             capacity;
  logic             iss;
  logic [CNT_W-1:0] cnt_nxt;

  // A writer leaving EXE this cycle no longer counts as in flight: its
  // flags reach the checker through the forwarding mux below. A write with
  // nothing pending is the underflow case and must not wrap the counter.
  assign retire   = exe_s_wr && (pend_cnt != '0);
  assign eff      = pend_cnt - CNT_W'(retire);

  // AL (0xE) and NV (0xF) both have cond[3:1] == 3'b111.
  assign uncond   = (id_cond[3:1] == 3'b111);
  assign hazard   = !uncond && (eff != '0);
  assign capacity = id_s && (eff == MAX_C);
  assign id_stall = id_valid && (hazard || capacity);

  // Stall is judged on pre-flush state; flush only discards the issue.
  assign iss      = id_valid && id_s && !id_stall && !flush;

  // capacity guarantees eff + iss never exceeds MAX_PEND.
  assign cnt_nxt  = flush ? '0 : (eff + CNT_W'(iss));

  assign chk_sr   = exe_s_wr ? exe_flags : sr;
  assign chk_cond = id_cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr            <= '0;
      pend_cnt      <= '0;
      underflow_err <= 1'b0;
    end else begin
      // flush squashes younger instructions only; the EXE write still lands.
      if (exe_s_wr) sr <= exe_flags;
      pend_cnt <= cnt_nxt;
      if (exe_s_wr && (pend_cnt == '0) && !flush) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flag_hazard_scheduler.sv
module tb_flag_hazard_scheduler;

  localparam int MAX_PEND = 2;
  localparam int CNT_W    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid = 1'b0;
  logic [3:0]       id_cond = 4'h0;
  logic             id_s = 1'b0;
  logic             flush = 1'b0;
  logic             exe_s_wr = 1'b0;
  logic [3:0]       exe_flags = 4'h0;
  logic [3:0]       sr;
  logic [3:0]       chk_sr;
  logic [3:0]       chk_cond;
  logic             id_stall;
  logic [CNT_W-1:0] pend_cnt;
  logic             underflow_err;

  int errs   = 0;
  int checks = 0;

  flag_hazard_scheduler #(.MAX_PEND(MAX_PEND), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_cond(id_cond),
    .id_s(id_s), .flush(flush), .exe_s_wr(exe_s_wr), .exe_flags(exe_flags),
    .sr(sr), .chk_sr(chk_sr), .chk_cond(chk_cond), .id_stall(id_stall),
    .pend_cnt(pend_cnt), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Number of older flag setters still to write, plus SR and error flag.
  int m_sr = 0;
  int m_inflight = 0;
  bit m_err = 0;

  function automatic int m_eff();
    // Writer leaving EXE is done; a stray write cannot make it negative.
    if (exe_s_wr && m_inflight > 0) return m_inflight - 1;
    return m_inflight;
  endfunction

  function automatic bit m_stall();
    bit reads_flags;
    reads_flags = (id_cond != 4'hE) && (id_cond != 4'hF);
    if (!id_valid) return 1'b0;
    if (reads_flags && m_eff() > 0) return 1'b1;
    if (id_s && m_eff() == MAX_PEND) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sr <= 0; m_inflight <= 0; m_err <= 0;
    end else begin
      if (exe_s_wr) m_sr <= int'(exe_flags);
      if (exe_s_wr && m_inflight == 0 && !flush) m_err <= 1;
      if (flush) m_inflight <= 0;
      else m_inflight <= m_eff() + ((id_valid && id_s && !m_stall()) ? 1 : 0);
    end
  end

  // Every falling edge: all outputs against the model.
  always @(negedge clk) begin
    check("m_sr", int'(sr), m_sr);
    check("m_pend_cnt", int'(pend_cnt), m_inflight);
    check("m_underflow", int'(underflow_err), int'(m_err));
    check("m_id_stall", int'(id_stall), int'(m_stall()));
    check("m_chk_sr", int'(chk_sr), exe_s_wr ? int'(exe_flags) : m_sr);
    check("m_chk_cond", int'(chk_cond), int'(id_cond));
  end

  task automatic drive(input bit v, input logic [3:0] c, input bit s,
                       input bit fl, input bit wr, input logic [3:0] f);
    id_valid = v; id_cond = c; id_s = s; flush = fl; exe_s_wr = wr; exe_flags = f;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    drive(0, 4'h0, 0, 0, 0, 4'h0);
    rst_n = 1'b0;
    tick(); tick();
    check("rst_sr", int'(sr), 0);
    check("rst_pend", int'(pend_cnt), 0);
    check("rst_stall", int'(id_stall), 0);
    check("rst_err", int'(underflow_err), 0);
    rst_n = 1'b1;
    tick();

    // Flag writer followed by a dependent EQ instruction.
    drive(1, 4'hE, 1, 0, 0, 4'h0);
    mid(); check("wr_issue_stall", int'(id_stall), 0);
    tick(); check("wr_pend1", int'(pend_cnt), 1);
    drive(1, 4'h0, 0, 0, 0, 4'h0);
    mid(); check("dep_stall", int'(id_stall), 1);
    tick(); check("dep_pend_hold", int'(pend_cnt), 1);
    drive(1, 4'h0, 0, 0, 1, 4'h4);
    mid(); check("fwd_stall", int'(id_stall), 0);
    check("fwd_chk_sr", int'(chk_sr), 4);
    tick(); check("fwd_sr", int'(sr), 4);
    check("fwd_pend0", int'(pend_cnt), 0);

    // Capacity.
    drive(1, 4'hE, 1, 0, 0, 4'h0);
    tick(); tick();
    check("cap_pend2", int'(pend_cnt), 2);
    mid(); check("cap_stall", int'(id_stall), 1);
    tick(); check("cap_pend_hold", int'(pend_cnt), 2);
    drive(1, 4'hE, 1, 0, 1, 4'h1);
    mid(); check("cap_retire_stall", int'(id_stall), 0);
    tick(); check("cap_swap_pend", int'(pend_cnt), 2);

    // Flush with a would-be issue and an EXE write in the same cycle.
    drive(1, 4'hE, 1, 1, 1, 4'h9);
    mid(); check("flush_stall", int'(id_stall), 0);
    tick();
    check("flush_pend0", int'(pend_cnt), 0);
    check("flush_sr", int'(sr), 9);
    check("flush_no_err", int'(underflow_err), 0);

    // Unconditional bypass.
    drive(1, 4'hE, 1, 0, 0, 4'h0);
    tick();
    drive(1, 4'hF, 0, 0, 0, 4'h0);
    mid(); check("nv_stall", int'(id_stall), 0);
    tick(); check("nv_pend", int'(pend_cnt), 1);
    // id_valid low masks a hazard.
    drive(0, 4'h1, 1, 0, 0, 4'h0);
    mid(); check("invalid_stall", int'(id_stall), 0);
    tick(); check("invalid_pend", int'(pend_cnt), 1);
    drive(0, 4'h0, 0, 0, 1, 4'h7);
    tick(); check("drain_pend", int'(pend_cnt), 0);

    // Flushed stray write does not flag underflow.
    drive(0, 4'h0, 0, 1, 1, 4'h3);
    tick(); check("flush_wr_no_err", int'(underflow_err), 0);
    check("flush_wr_sr", int'(sr), 3);

    // Underflow, sticky.
    drive(0, 4'h0, 0, 0, 1, 4'h2);
    tick();
    check("uf_sr", int'(sr), 2);
    check("uf_err", int'(underflow_err), 1);
    check("uf_pend", int'(pend_cnt), 0);
    drive(0, 4'h0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 10; i++) tick();
    check("uf_sticky", int'(underflow_err), 1);

    // Mixed vectors, checked by the model only.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
      tick();
    end

    // Reset mid-operation, applied away from the clock edge.
    drive(1, 4'hE, 1, 0, 0, 4'h0);
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_pend", int'(pend_cnt), 0);
    check("arst_err", int'(underflow_err), 0);
    check("arst_sr", int'(sr), 0);
    tick();
    rst_n = 1'b1;
    drive(0, 4'h0, 0, 0, 0, 4'h0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
